// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 reference timing and the test-pattern mode encodings.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic [1:0] MODE_GRID  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_PASS  = 2'd3;

endpackage

// File: rtl/vga_pattern.sv
// Test-pattern source (grid, colour bars, checker, passthrough) gated by data-enable.
// Only exists when VGA_TEST_PATTERN_EN is defined.
`ifdef VGA_TEST_PATTERN_EN
module vga_pattern
    import vga_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int COLOR_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   line_tick,
    input  logic                   frame_tick,
    input  logic [1:0]             mode,
    input  logic [XW-1:0]          x,
    input  logic [YW-1:0]          y,
    input  logic                   de,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b
);

    localparam int            RGB_W    = 3 * COLOR_W;
    localparam int            BAR_W    = H_ACTIVE / 8;
    localparam int            BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BPX_LAST = BW'(BAR_W - 1);
    localparam logic [XW-1:0] H_ACT_L  = XW'(H_ACTIVE);

    logic [1:0]       mode_q, mode_d;
    logic [2:0]       bar_q, bar_d;
    logic [BW-1:0]    bpx_q, bpx_d;
    logic [2:0]       code;
    logic [RGB_W-1:0] pat;
    logic             unused_y;

    assign unused_y = ^y;

    // Bar state tracks the pixel currently on x: the increment accounts for the pixel being left.
    always_comb begin
        mode_d = mode_q;
        bar_d  = bar_q;
        bpx_d  = bpx_q;
        if (frame_tick) begin
            mode_d = mode;
        end
        if (line_tick) begin
            bar_d = '0;
            bpx_d = '0;
        end else if (tick && (x < H_ACT_L)) begin
            if (bpx_q == BPX_LAST) begin
                bpx_d = '0;
                if (bar_q != 3'd7) begin
                    bar_d = bar_q + 3'd1;
                end
            end else begin
                bpx_d = bpx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_PASS;
            bar_q  <= '0;
            bpx_q  <= '0;
        end else begin
            mode_q <= mode_d;
            bar_q  <= bar_d;
            bpx_q  <= bpx_d;
        end
    end

    always_comb begin
        code = 3'd7 - bar_q;
        pat  = rgb_in;
        case (mode_q)
            MODE_GRID:  pat = {RGB_W{(x[3:0] == 4'd0) || (y[3:0] == 4'd0)}};
            MODE_BARS:  pat = {{COLOR_W{code[1]}}, {COLOR_W{code[2]}}, {COLOR_W{code[0]}}};
            MODE_CHECK: pat = {RGB_W{x[5] ^ y[5]}};
            default:    pat = rgb_in;
        endcase
    end

    assign {r, g, b} = de ? pat : '0;

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with DE, coordinates, line/frame strobes and gated RGB.
// Define VGA_TEST_PATTERN_EN to insert the vga_pattern source in front of the RGB gate.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = VGA_H_ACTIVE,
    parameter int   H_FP      = VGA_H_FP,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BP      = VGA_H_BP,
    parameter int   V_ACTIVE  = VGA_V_ACTIVE,
    parameter int   V_FP      = VGA_V_FP,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BP      = VGA_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CLK_DIV   = 2,
    parameter int   COLOR_W   = 1,
    localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW        = $clog2(H_TOTAL),
    localparam int  YW        = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic                 pix_en,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [XW-1:0]        x,
    output logic [YW-1:0]        y,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_ACT_L  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_L  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

    logic [DW-1:0] div_q, div_d;
    logic [XW-1:0] hcnt_q, hcnt_d, x_q, x_d;
    logic [YW-1:0] vcnt_q, vcnt_d, y_q, y_d;
    logic          pix_en_q, pix_en_d, de_q, de_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    // Outputs register the counter value of the current tick, so pix_en marks the cycle they change.
    always_comb begin
        div_d         = div_q + 1'b1;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        pix_en_d      = tick;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (tick) begin
            div_d         = '0;
            x_d           = hcnt_q;
            y_d           = vcnt_q;
            de_d          = (hcnt_q < H_ACT_L) && (vcnt_q < V_ACT_L);
            hsync_d       = ((hcnt_q >= HS_START) && (hcnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = ((vcnt_q >= VS_START) && (vcnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (hcnt_q == '0);
            frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pix_en_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pix_en_q      <= pix_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    logic line_tick, frame_tick;

    assign line_tick  = tick && (hcnt_q == '0);
    assign frame_tick = line_tick && (vcnt_q == '0);

    vga_pattern #(
        .XW       (XW),
        .YW       (YW),
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W)
    ) u_pattern (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .line_tick  (line_tick),
        .frame_tick (frame_tick),
        .mode       (mode),
        .x          (x_q),
        .y          (y_q),
        .de         (de_q),
        .rgb_in     (rgb_in),
        .r          (r),
        .g          (g),
        .b          (b)
    );
`else
    logic unused_mode;

    assign unused_mode = ^mode;
    assign {r, g, b}   = de_q ? rgb_in : '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, inverted polarity with CLK_DIV=1,
// and a reduced raster for full-frame and mode-change coverage.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic [1:0] mode0, mode1, mode2;
    logic [2:0] rgb_in;

    logic       pe0, hs0, vs0, de0, ls0, fs0, r0, g0, b0;
    logic [9:0] x0, y0;
    logic       pe1, hs1, vs1, de1, ls1, fs1, r1, g1, b1;
    logic [9:0] x1, y1;
    logic       pe2, hs2, vs2, de2, ls2, fs2, r2, g2, b2;
    logic [6:0] x2;
    logic [3:0] y2;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst0), .mode(mode0), .rgb_in(rgb_in), .pix_en(pe0),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .r(r0), .g(g0), .b(b0)
    );

    vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst1), .mode(mode1), .rgb_in(rgb_in), .pix_en(pe1),
        .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .r(r1), .g(g1), .b(b1)
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .mode(mode2), .rgb_in(rgb_in), .pix_en(pe2),
        .hsync(hs2), .vsync(vs2), .de(de2), .x(x2), .y(y2),
        .line_start(ls2), .frame_start(fs2), .r(r2), .g(g2), .b(b2)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_pe0();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pe0 !== 1'b1 && n < 8);
        if (pe0 !== 1'b1) check_vec("pe0_timeout", pe0, 1);
    endtask

    task automatic wait_pe2();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pe2 !== 1'b1 && n < 8);
        if (pe2 !== 1'b1) check_vec("pe2_timeout", pe2, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat0 = 0, lat1 = 0, fx = -1, fy = -1, ffs = -1, fde = -1, fls = -1;
        int xseq_bad = 0, hs_cnt0 = 0, hs_cnt1 = 0, hs_first = -1, hs_last = -1;
        int de_cnt = 0, de_bad = 0, rgb_bad = 0, per = 0, ls_cyc = 0;
        int lx = -1, ly = -1, nx = -1, ny = -1, nls = -1, nfs = -1, n = 0, c0 = 0;
        int pe_cnt = 0, hh_cnt = 0, hh_first = -1, hh_last = -1, vs1_bad = 0, x1_bad = 0;
        int vs_cnt = 0, vs_first = -1, vs_last = -1, hs2_cnt = 0, de2_cnt = 0, de2_bad = 0;
        int fs_cnt = 0, pos_bad = 0, per2 = 0, c2 = 0, wx = -1, wy = -1, ex = -1, ey = -1;
        int fx2 = -1, fy2 = -1, ffs2 = -1, pass_bad = 0;
        logic [2:0] rgb_f2_x0, rgb_f2_x10, rgb_f2_x40;
        logic [2:0] exp_x0, exp_x10, exp_x40;
        logic [2:0] bars [8];

        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
`ifdef VGA_TEST_PATTERN_EN
        exp_x0 = 3'b000; exp_x10 = 3'b000; exp_x40 = 3'b111;
`else
        exp_x0 = 3'b101; exp_x10 = 3'b101; exp_x40 = 3'b101;
`endif
        rgb_f2_x0 = 'x; rgb_f2_x10 = 'x; rgb_f2_x40 = 'x;

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        mode0 = 2'd3; mode1 = 2'd3; mode2 = 2'd3;
        rgb_in = 3'b101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("rst_pix_en", pe0, 0);
        check_vec("rst_x", x0, 0);
        check_vec("rst_y", y0, 0);
        check_vec("rst_de", de0, 0);
        check_vec("rst_line_start", ls0, 0);
        check_vec("rst_frame_start", fs0, 0);
        check_vec("rst_hsync", hs0, 1);
        check_vec("rst_vsync", vs0, 1);
        check_vec("rst_rgb", {r0, g0, b0}, 0);
        check_vec("rst_hsync_pol1", hs1, 0);
        check_vec("rst_vsync_pol1", vs1, 0);
        check_vec("rst_pix_en_div1", pe1, 0);

        // Release and measure first-tick latency for CLK_DIV=2 and CLK_DIV=1
        rst0 = 1'b0; rst1 = 1'b0;
        for (int k = 1; k <= 8 && lat0 == 0; k++) begin
            @(negedge clk);
            if (pe1 === 1'b1 && lat1 == 0) lat1 = k;
            if (pe0 === 1'b1) begin
                lat0 = k; fx = x0; fy = y0; ffs = fs0; fde = de0; fls = ls0;
            end
        end
        check_vec("first_tick_latency", lat0, 2);
        check_vec("first_tick_latency_div1", lat1, 1);
        check_vec("first_x", fx, 0);
        check_vec("first_y", fy, 0);
        check_vec("first_frame_start", ffs, 1);
        check_vec("first_line_start", fls, 1);
        check_vec("first_de", fde, 1);

        // Two full default lines
        ls_cyc = cyc;
        for (int t = 0; t < 1600; t++) begin
            if (t > 0) wait_pe0();
            if (x0 !== 10'(t % 800)) xseq_bad++;
            if (hs0 === 1'b0) begin
                if (t < 800) begin
                    hs_cnt0++;
                    if (hs_first < 0) hs_first = int'(x0);
                    hs_last = int'(x0);
                end else begin
                    hs_cnt1++;
                end
            end
            if (t < 800) begin
                if (de0 === 1'b1) de_cnt++;
                if (de0 === 1'b1 && x0 >= 10'd640) de_bad++;
            end
            if ({r0, g0, b0} !== (((t % 800) < 640) ? 3'b101 : 3'b000)) rgb_bad++;
            if (t == 799) begin lx = int'(x0); ly = int'(y0); end
            if (t == 800) begin
                per = cyc - ls_cyc; nx = int'(x0); ny = int'(y0); nls = ls0; nfs = fs0;
            end
        end
        check_vec("x_sequence_errors", xseq_bad, 0);
        check_vec("hsync_low_ticks_line0", hs_cnt0, 96);
        check_vec("hsync_low_first_x", hs_first, 656);
        check_vec("hsync_low_last_x", hs_last, 751);
        check_vec("hsync_low_ticks_line1", hs_cnt1, 96);
        check_vec("de_ticks_line0", de_cnt, 640);
        check_vec("de_high_x_ge_640", de_bad, 0);
        check_vec("passthrough_rgb_errors", rgb_bad, 0);
        check_vec("line_period_clk", per, 1600);
        check_vec("line_end_x", lx, 799);
        check_vec("line_end_y", ly, 0);
        check_vec("wrap_x", nx, 0);
        check_vec("wrap_y", ny, 1);
        check_vec("wrap_line_start", nls, 1);
        check_vec("wrap_frame_start", nfs, 0);

        // Mid-frame reset at x=300, y=2
        n = 0;
        while (!(x0 == 10'd300 && y0 == 10'd2) && n < 2000) begin
            wait_pe0();
            n++;
        end
        check_vec("reach_x300", x0, 300);
        check_vec("reach_y2", y0, 2);
        check_vec("pre_reset_de", de0, 1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        c0 = cyc;
        check_vec("midrst_x", x0, 0);
        check_vec("midrst_y", y0, 0);
        check_vec("midrst_de", de0, 0);
        check_vec("midrst_hsync", hs0, 1);
        check_vec("midrst_vsync", vs0, 1);
        check_vec("midrst_pix_en", pe0, 0);
        check_vec("midrst_frame_start", fs0, 0);
        wait_pe0();
        check_vec("restart_latency", cyc - c0, 2);
        check_vec("restart_x", x0, 0);
        check_vec("restart_y", y0, 0);
        check_vec("restart_frame_start", fs0, 1);
        wait_pe0();
        check_vec("restart_x_next", x0, 1);

        // Positive polarity, CLK_DIV=1: one line from reset
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (pe1 === 1'b1) pe_cnt++;
            if (x1 !== 10'(c)) x1_bad++;
            if (vs1 !== 1'b0) vs1_bad++;
            if (hs1 === 1'b1) begin
                hh_cnt++;
                if (hh_first < 0) hh_first = int'(x1);
                hh_last = int'(x1);
            end
        end
        check_vec("div1_pix_en_count", pe_cnt, 800);
        check_vec("div1_x_sequence_errors", x1_bad, 0);
        check_vec("pol1_vsync_active_y0", vs1_bad, 0);
        check_vec("pol1_hsync_high_ticks", hh_cnt, 96);
        check_vec("pol1_hsync_first_x", hh_first, 656);
        check_vec("pol1_hsync_last_x", hh_last, 751);

        // Reduced raster 72x15: full frame, wraps, and a mid-frame mode change
        rst2 = 1'b0;
        wait_pe2();
        c2 = cyc;
        for (int t = 0; t < 2232; t++) begin
            if (t > 0) wait_pe2();
            if (x2 !== 7'(t % 72) || y2 !== 4'((t / 72) % 15)) pos_bad++;
            if (t < 1080) begin
                if (vs2 === 1'b0) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = int'(y2);
                    vs_last = int'(y2);
                end
                if (hs2 === 1'b0) hs2_cnt++;
                if (de2 === 1'b1) de2_cnt++;
                if (de2 === 1'b1 && (x2 >= 7'd64 || y2 >= 4'd8)) de2_bad++;
                if (fs2 === 1'b1) fs_cnt++;
            end
            if (t == 72) begin wx = int'(x2); wy = int'(y2); end
            if (t == 1079) begin ex = int'(x2); ey = int'(y2); end
            if (t == 1080) begin
                fx2 = int'(x2); fy2 = int'(y2); ffs2 = fs2; per2 = cyc - c2;
            end
            if (t == 1296) mode2 = 2'd2;
            if (t >= 1296 && t < 2160 && de2 === 1'b1 && {r2, g2, b2} !== 3'b101) pass_bad++;
            if (t == 2160) rgb_f2_x0 = {r2, g2, b2};
            if (t == 2170) rgb_f2_x10 = {r2, g2, b2};
            if (t == 2200) rgb_f2_x40 = {r2, g2, b2};
        end
        check_vec("small_position_errors", pos_bad, 0);
        check_vec("small_vsync_low_ticks", vs_cnt, 144);
        check_vec("small_vsync_first_y", vs_first, 10);
        check_vec("small_vsync_last_y", vs_last, 11);
        check_vec("small_hsync_low_ticks", hs2_cnt, 60);
        check_vec("small_de_ticks", de2_cnt, 512);
        check_vec("small_de_outside_active", de2_bad, 0);
        check_vec("small_frame_start_count", fs_cnt, 1);
        check_vec("small_hwrap_x", wx, 0);
        check_vec("small_hwrap_y", wy, 1);
        check_vec("small_frame_end_x", ex, 71);
        check_vec("small_frame_end_y", ey, 14);
        check_vec("small_vwrap_x", fx2, 0);
        check_vec("small_vwrap_y", fy2, 0);
        check_vec("small_vwrap_frame_start", ffs2, 1);
        check_vec("small_frame_period_clk", per2, 1080);
        check_vec("mode_change_held_until_frame", pass_bad, 0);
        check_vec("next_frame_rgb_x0", rgb_f2_x0, exp_x0);
        check_vec("next_frame_rgb_x10", rgb_f2_x10, exp_x10);
        check_vec("next_frame_rgb_x40", rgb_f2_x40, exp_x40);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars on the default raster
        mode0 = 2'd1;
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        for (int t = 0; t < 640; t++) begin
            wait_pe0();
            if ((t % 80) == 0 || (t % 80) == 79)
                check_vec($sformatf("bars_x%0d", t), {x0, r0, g0, b0}, {10'(t), bars[t / 80]});
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
